// File: rtl/pw_not_equal_pkg.sv
// Shared types and width helpers for the pw_not_equal race-logic "not equal" operator.
package pw_not_equal_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int GAMMA_CYCLE_WIDTH_DEF = 16;
    localparam int PULSE_WIDTH_DEF       = 8;

    // Bits needed to hold max_val; never returns zero so one-bit counters stay legal.
    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int CNT_W = width_for(PULSE_WIDTH_DEF);
    localparam int WIN_W = width_for(GAMMA_CYCLE_WIDTH_DEF - 1);

endpackage

// File: rtl/pw_not_equal_first_edge.sv
// First rising edge detector: flags the first 0->1 transition of sig_i after grst, once per gamma cycle.
module pw_first_edge (
    input  logic aclk,
    input  logic grst,
    input  logic sig_i,
    input  logic win_open_i,
    output logic ev_o
);

    logic prev_q, prev_d;
    logic seen_q, seen_d;

    // NOTE: every always_comb output gets a value before any branch, so no latch can be inferred.
    always_comb begin
        ev_o   = sig_i & ~prev_q & ~seen_q & win_open_i;
        prev_d = sig_i;
        seen_d = seen_q | ev_o;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (grst) begin
            // Capturing the live input here means a level held across grst is not an edge.
            prev_q <= sig_i;
            seen_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/pw_not_equal.sv
// Temporal "not equal": y reproduces a's event unless b's event lands in the same aclk cycle.
// Build option: define PW_NOT_EQUAL_LEVEL_OUT_EN for a level output held until grst instead of a pulse.
module pw_not_equal
    import pw_not_equal_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
    parameter int PULSE_WIDTH       = PULSE_WIDTH_DEF
) (
    input  logic aclk,
    input  logic grst,
    input  logic a,
    input  logic b,
    output logic y
);

    localparam int WIN_WIDTH = width_for(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [WIN_WIDTH-1:0] WIN_MAX = WIN_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

    state_e               state_q, state_d;
    logic                 y_q, y_d;
    logic [WIN_WIDTH-1:0] win_q, win_d;
    logic                 win_open;
    logic                 ev_a, ev_b;

`ifndef PW_NOT_EQUAL_LEVEL_OUT_EN
    localparam int CNT_WIDTH = width_for(PULSE_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(PULSE_WIDTH);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`endif

    assign win_open = (win_q != WIN_MAX);

    pw_first_edge u_edge_a (
        .aclk       (aclk),
        .grst       (grst),
        .sig_i      (a),
        .win_open_i (win_open),
        .ev_o       (ev_a)
    );

    pw_first_edge u_edge_b (
        .aclk       (aclk),
        .grst       (grst),
        .sig_i      (b),
        .win_open_i (win_open),
        .ev_o       (ev_b)
    );

    always_comb begin
        state_d = state_q;
        y_d     = 1'b0;
        win_d   = win_open ? win_q + 1'b1 : win_q;
`ifndef PW_NOT_EQUAL_LEVEL_OUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (ev_a && !ev_b) begin
                    state_d = FIRE;
                    y_d     = 1'b1;
`ifndef PW_NOT_EQUAL_LEVEL_OUT_EN
                    cnt_d   = CNT_WIDTH'(1);
`endif
                end else if (ev_a && ev_b) begin
                    state_d = DONE;
                end
            end
            FIRE: begin
`ifdef PW_NOT_EQUAL_LEVEL_OUT_EN
                y_d = 1'b1;
`else
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    y_d   = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: only control state is reset here; there is no memory array that would need clearing.
    always_ff @(posedge aclk) begin
        if (grst) begin
            state_q <= IDLE;
            y_q     <= 1'b0;
            win_q   <= '0;
`ifndef PW_NOT_EQUAL_LEVEL_OUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            win_q   <= win_d;
`ifndef PW_NOT_EQUAL_LEVEL_OUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_pw_not_equal.sv
// Directed bench for pw_not_equal; expected y per edge is queued at drive time and checked at the next negedge.
module tb_pw_not_equal;

    localparam int PW = 8;
`ifdef PW_NOT_EQUAL_LEVEL_OUT_EN
    localparam bit LEVEL = 1'b1;
`else
    localparam bit LEVEL = 1'b0;
`endif

    logic aclk = 1'b0;
    logic grst = 1'b1;
    logic a    = 1'b0;
    logic b    = 1'b0;
    logic y;

    logic exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 aclk = ~aclk;

    pw_not_equal dut (
        .aclk (aclk),
        .grst (grst),
        .a    (a),
        .b    (b),
        .y    (y)
    );

    // Expected y, k edges after the edge that first samples a's event.
    function automatic logic exp_pulse(input int k);
        return LEVEL ? 1'b1 : logic'(k < PW);
    endfunction

    task automatic step(input logic g, input logic av, input logic bv,
                        input logic ey, input string tag);
        logic e;
        grst = g;
        a    = av;
        b    = bv;
        exp_q.push_back(ey);
        @(posedge aclk);
        @(negedge aclk);
        e = exp_q.pop_front();
        checks++;
        assert (y === e) else begin
            failures++;
            $error("FAIL %s: y=%b expected=%b", tag, y, e);
        end
    endtask

    initial begin
        @(negedge aclk);

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 1'b0, "reset");

        // No events for a full gamma cycle, then a late edge past the window.
        for (int e = 1; e <= 16; e++)
            step(1'b0, 1'b0, 1'b0, 1'b0, $sformatf("idle_e%0d", e));
        for (int e = 17; e <= 20; e++)
            step(1'b0, 1'b1, 1'b0, 1'b0, $sformatf("late_e%0d", e));

        // a then b; a toggles low/high again later without a second pulse.
        step(1'b1, 1'b0, 1'b0, 1'b0, "a_first_rst");
        for (int e = 1; e <= 16; e++)
            step(1'b0, logic'((e >= 3 && e <= 10) || e >= 13), logic'(e >= 5 && e <= 10),
                 (e >= 3) ? exp_pulse(e - 3) : 1'b0, $sformatf("a_first_e%0d", e));

        // b then a.
        step(1'b1, 1'b0, 1'b0, 1'b0, "b_first_rst");
        for (int e = 1; e <= 16; e++)
            step(1'b0, logic'(e >= 5), logic'(e >= 3),
                 (e >= 5) ? exp_pulse(e - 5) : 1'b0, $sformatf("b_first_e%0d", e));

        // a and b coincide, fall together, then a rises again.
        step(1'b1, 1'b0, 1'b0, 1'b0, "same_rst");
        for (int e = 1; e <= 14; e++)
            step(1'b0, logic'((e >= 3 && e <= 8) || e >= 11), logic'(e >= 3 && e <= 8),
                 1'b0, $sformatf("same_e%0d", e));

        // grst mid-pulse, then a fresh event in the next gamma cycle.
        step(1'b1, 1'b0, 1'b0, 1'b0, "abort_rst");
        step(1'b0, 1'b0, 1'b0, 1'b0, "abort_e1");
        for (int e = 2; e <= 4; e++)
            step(1'b0, 1'b1, 1'b0, exp_pulse(e - 2), $sformatf("abort_e%0d", e));
        step(1'b1, 1'b1, 1'b0, 1'b0, "abort_grst");
        for (int e = 1; e <= 14; e++)
            step(1'b0, logic'(e >= 3), 1'b0,
                 (e >= 3) ? exp_pulse(e - 3) : 1'b0, $sformatf("rearm_e%0d", e));

        // a held high across grst and falling are not events; the next true rise is.
        step(1'b1, 1'b1, 1'b0, 1'b0, "held_rst");
        for (int e = 1; e <= 12; e++)
            step(1'b0, logic'(e != 2), 1'b0,
                 (e >= 3) ? exp_pulse(e - 3) : 1'b0, $sformatf("held_e%0d", e));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pw_not_equal.md
Name: pw_not_equal

Overview:
- Space-time (race-logic) "not equal" operator for pulse-width encoded temporal signals.
- Each input carries at most one event per gamma cycle; the event is the input's first rising edge after `grst`.
- `y` reproduces the `a` event (at `a`'s time) only if `b`'s event does not occur in the same aclk cycle; otherwise `y` stays silent (infinity).
- Sits among the primitive temporal operators in a gamma-cycle-framed TNN datapath.

Parameters:
- GAMMA_CYCLE_WIDTH, 16: aclk cycles per gamma cycle; sets the event-acceptance window.
- PULSE_WIDTH, 8: number of cycles `y` stays high per output event; must be >=1 and < GAMMA_CYCLE_WIDTH.

Ports:
- aclk  input  1  single clock, all state on posedge.
- grst  input  1  gamma reset, synchronous, active-high; marks the start of a gamma cycle.
- a     input  1  temporal input A; event = first 0->1 transition.
- b     input  1  temporal input B; event = first 0->1 transition.
- y     output 1  temporal output, registered.

Behaviour:
- Reset: the already-decided single clock is `aclk`; `grst` is synchronous and active-high. While `grst` is high at a posedge:
  - y=0, state=IDLE, pulse counter=0, window counter=0, a_seen=b_seen=0.
  - a_prev<=a and b_prev<=b, so an input held high across reset creates no event.
- `grst` has priority over all other activity, including mid-pulse: y drops at that edge.
- Event detection, at each posedge with grst=0 and window counter < GAMMA_CYCLE_WIDTH-1:
  - ev_a = a & ~a_prev & ~a_seen; ev_b likewise.
  - a_seen / b_seen set on their events; a_prev<=a, b_prev<=b every cycle.
- Window counter: increments each cycle after reset and saturates at GAMMA_CYCLE_WIDTH-1. Once saturated, edges are ignored.
- FSM states:
  - IDLE: ev_a & ~ev_b -> FIRE, y<=1, cnt<=1. ev_a & ev_b -> DONE, y stays 0. Otherwise stay in IDLE; a prior b event does not block a later a event.
  - FIRE: y=1. If cnt==PULSE_WIDTH -> DONE, y<=0; else cnt++. b events during FIRE are ignored.
  - DONE: y=0 until grst. Later a/b edges are ignored.
- Latency: y rises at the same posedge that first samples a=1, i.e. one cycle after `a` changes following a posedge. y is high for exactly PULSE_WIDTH cycles.
- Boundary conditions:
  - b never arrives -> y fires (a ≠ ∞).
  - a never arrives -> y never fires.
  - Toggling a low then high again within the gamma cycle produces no second pulse.
  - An input high-to-low transition is never an event.

Optional Feature:
- Macro PW_NOT_EQUAL_LEVEL_OUT_EN.
- Defined: y is level-encoded. It rises as above and stays high until grst; FIRE never exits on count, and the pulse counter is not synthesized.
- Undefined (default): pulse-width output of PULSE_WIDTH cycles as specified.

Decomposition:
- Package pw_not_equal_pkg:
  - state enum (IDLE, FIRE, DONE), 2-bit logic.
  - width helper localparams: CNT_W = $clog2(PULSE_WIDTH+1), WIN_W = $clog2(GAMMA_CYCLE_WIDTH).
- Sub-module pw_first_edge: prev-sample register, seen flag and one-cycle ev output with grst handling. Instantiated once for `a` and once for `b`; FSM and counters stay in the top.

Test Plan:
- No input events for a full gamma cycle of 16 cycles after grst -> y stays 0 throughout.
- a rises 2 cycles after reset, b rises 2 cycles later, a/b fall after 8 cycles -> y high for exactly 8 cycles starting the edge a is sampled; b has no effect.
- b rises 2 cycles after reset, a rises 2 cycles later -> y high for 8 cycles starting at a's sample edge.
- a and b rise in the same cycle -> y stays 0 until next grst; falling together later also gives y=0.
- Assert grst at cycle 3 of an active y pulse -> y=0 at that edge; a fresh a event next gamma cycle fires a full 8-cycle pulse.
- With PW_NOT_EQUAL_LEVEL_OUT_EN, a then b -> y stays high from a's edge until grst, regardless of a falling.
